branch_pred_ctrl: RTL and testbench

- Schedules branch resolution around the EX-stage comparator of the pipelined RV32I core.
- ID stage: issues a taken/not-taken prediction from a table of 2-bit saturating counters indexed by PC.
- EX stage: takes the comparator outcome, generates flush and redirect on a mispredict, trains the table, and keeps branch/mispredict performance counters.

---
 rtl/branch_pred_ctrl.sv | 116 +++++++++++
 tb/tb_branch_pred_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_ctrl.sv
// ---------------------------------------------------------------------------
// branch_pred_ctrl
//   Branch prediction and resolution controller for the pipelined RV32I core.
//   The ID stage gets a combinational taken/not-taken guess from a table of
//   2-bit saturating counters indexed by pc[IDX_W+1:2]. The EX stage resolves
//   the branch against the comparator. On a wrong guess it raises flush and
//   supplies the corrected fetch PC in the same cycle. It also trains the
//   table and counts resolved and mispredicted branches.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   id_is_branch      ID instruction is a conditional branch
//   id_pc             PC of the ID instruction
//   id_pred_taken     prediction for the ID instruction (combinational)
//   ex_valid          EX holds a live instruction
//   ex_stall          EX held this cycle; comparator result not final
//   ex_is_branch      EX instruction is a conditional branch
//   ex_pc             PC of the EX instruction
//   ex_pred_taken     prediction carried down from ID
//   ex_cmp_taken      comparator outcome
//   ex_target         computed branch target
//   flush             squash IF/ID and ID/EX this cycle
//   redirect_pc       next fetch PC while flush=1, else 0
//   branch_cnt        resolved branches since reset
//   mispred_cnt       mispredicted branches since reset
// ---------------------------------------------------------------------------
module branch_pred_ctrl #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_is_branch,
    input  logic [31:0]      id_pc,
    output logic             id_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic             ex_cmp_taken,
    input  logic [31:0]      ex_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    localparam logic [1:0] CTR_RESET = 2'b01;

    logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
    logic [CNT_W-1:0]        branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]        mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] id_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             res;
    logic             mis;

    assign id_idx = id_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // The prediction reads registered table state, so a same-index update in
    // this cycle is not bypassed. ID sees the pre-update value.
    assign id_pred_taken = id_is_branch & ctr_q[id_idx][1];

    // Gating with rst keeps flush and redirect quiet during reset. It also
    // blocks training on the reset edge.
    assign res = ex_valid & ex_is_branch & ~ex_stall & ~rst;
    assign mis = res & (ex_pred_taken != ex_cmp_taken);

    always_comb begin
        flush       = mis;
        redirect_pc = 32'h0;
        if (mis) begin
            // The not-taken fall-through wraps naturally at 32 bits.
            redirect_pc = ex_cmp_taken ? ex_target : (ex_pc + 32'd4);
        end
    end

    always_comb begin
        ctr_d         = ctr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (res) begin
            if (ex_cmp_taken) begin
                if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
            end else begin
                if (ctr_q[ex_idx] != 2'b00) ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
            end
            branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (mis) begin
            mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q         <= {ENTRIES{CTR_RESET}};
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ctr_q         <= ctr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
module tb_branch_pred_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_is_branch;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic        ex_valid, ex_stall, ex_is_branch, ex_pred_taken, ex_cmp_taken;
    logic [31:0] ex_pc, ex_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt, mispred_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: one integer strength 0..3 per entry, plus counts.
    int          m_tbl [16];
    logic [31:0] m_br, m_mis;

    branch_pred_ctrl #(.IDX_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_is_branch(id_is_branch), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .ex_cmp_taken(ex_cmp_taken),
        .ex_target(ex_target), .flush(flush), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic exp_pred();
        return id_is_branch && (m_tbl[idx_of(id_pc)] >= 2);
    endfunction

    function automatic logic exp_res();
        return ex_valid && ex_is_branch && !ex_stall && !rst;
    endfunction

    function automatic logic exp_mis();
        return exp_res() && (ex_pred_taken != ex_cmp_taken);
    endfunction

    function automatic logic [31:0] exp_redirect();
        if (!exp_mis()) return 32'h0;
        return ex_cmp_taken ? ex_target : ex_pc + 32'd4;
    endfunction

    // Advance one clock. The model is updated from the inputs that were
    // presented at the edge. The task returns 1 time unit after the edge.
    task automatic cycle();
        logic r, m, t;
        int   i;
        r = exp_res(); m = exp_mis(); t = ex_cmp_taken; i = idx_of(ex_pc);
        @(posedge clk);
        if (rst) begin
            foreach (m_tbl[k]) m_tbl[k] = 1;
            m_br = 0; m_mis = 0;
        end else if (r) begin
            if (t) m_tbl[i] = (m_tbl[i] == 3) ? 3 : m_tbl[i] + 1;
            else   m_tbl[i] = (m_tbl[i] == 0) ? 0 : m_tbl[i] - 1;
            m_br = m_br + 1;
            if (m) m_mis = m_mis + 1;
        end
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic st, input logic br,
                            input logic [31:0] pc, input logic pt, input logic ct,
                            input logic [31:0] tgt);
        ex_valid = v; ex_stall = st; ex_is_branch = br; ex_pc = pc;
        ex_pred_taken = pt; ex_cmp_taken = ct; ex_target = tgt;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1; id_is_branch = 1'b1; id_pc = 32'h100;
        // A mispredicting branch sits in EX during reset. It must stay silent.
        drive_ex(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80);
        cycle(); cycle();
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b exp=0", flush); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_redirect got=%h exp=0", redirect_pc); end
        rst = 1'b0; idle_ex();
        cycle();
        total++; if (id_pred_taken !== 1'b0) begin bad++; $display("FAIL rst_pred got=%b exp=0", id_pred_taken); end
        total++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_idle_flush got=%b exp=0", flush); end
        id_is_branch = 1'b0; #1;
        total++; if (id_pred_taken !== 1'b0) begin bad++; $display("FAIL nonbranch_pred got=%b exp=0", id_pred_taken); end
    endtask

    task automatic test_mispredict();
        id_is_branch = 1'b1; id_pc = 32'h100;
        drive_ex(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80);
        #3;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL mis_flush got=%b exp=1", flush); end
        total++; if (redirect_pc !== 32'h80) begin bad++; $display("FAIL mis_redirect got=%h exp=00000080", redirect_pc); end
        cycle(); idle_ex(); #1;
        total++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin
            bad++; $display("FAIL mis_cnt got=%0d/%0d exp=1/1", branch_cnt, mispred_cnt); end
        total++; if (id_pred_taken !== 1'b1) begin bad++; $display("FAIL mis_trained_pred got=%b exp=1", id_pred_taken); end
    endtask

    task automatic test_saturate();
        id_is_branch = 1'b1; id_pc = 32'h100;
        for (int k = 0; k < 3; k++) begin
            drive_ex(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h80);
            #3;
            total++; if (flush !== 1'b0) begin bad++; $display("FAIL sat_flush%0d got=%b exp=0", k, flush); end
            cycle();
        end
        drive_ex(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80);
        #3;
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h104) begin
            bad++; $display("FAIL sat_nt_redirect got=%b/%h exp=1/00000104", flush, redirect_pc); end
        cycle(); idle_ex(); #1;
        // 11 -> 10 still predicts taken.
        total++; if (id_pred_taken !== 1'b1) begin bad++; $display("FAIL sat_pred got=%b exp=1", id_pred_taken); end
        total++; if (m_tbl[0] != 2) begin bad++; $display("FAIL sat_model got=%0d exp=2", m_tbl[0]); end
        total++; if (branch_cnt !== m_br || mispred_cnt !== m_mis) begin
            bad++; $display("FAIL sat_cnt got=%0d/%0d exp=%0d/%0d", branch_cnt, mispred_cnt, m_br, m_mis); end
    endtask

    task automatic test_stall();
        logic [31:0] br0, mis0;
        br0 = m_br; mis0 = m_mis;
        for (int k = 0; k < 3; k++) begin
            drive_ex(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, k[0], 32'h40);
            #3;
            total++; if (flush !== 1'b0) begin bad++; $display("FAIL stall_flush%0d got=%b exp=0", k, flush); end
            cycle();
            total++; if (branch_cnt !== br0 || mispred_cnt !== mis0) begin
                bad++; $display("FAIL stall_cnt%0d got=%0d/%0d exp=%0d/%0d", k, branch_cnt, mispred_cnt, br0, mis0); end
        end
        // Entry 0 is weak taken here, so a carried not-taken guess mispredicts.
        drive_ex(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h40);
        #3;
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h40) begin
            bad++; $display("FAIL unstall_flush got=%b/%h exp=1/00000040", flush, redirect_pc); end
        cycle(); idle_ex(); #3;
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL unstall_single got=%b exp=0", flush); end
        total++; if (branch_cnt !== br0 + 32'd1 || mispred_cnt !== mis0 + 32'd1) begin
            bad++; $display("FAIL unstall_cnt got=%0d/%0d exp=%0d/%0d", branch_cnt, mispred_cnt, br0 + 1, mis0 + 1); end
    endtask

    task automatic test_same_index();
        id_is_branch = 1'b1; id_pc = 32'h14;
        drive_ex(1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 1'b1, 32'h300);
        #3;
        total++; if (id_pred_taken !== 1'b0) begin bad++; $display("FAIL same_idx_old got=%b exp=0", id_pred_taken); end
        cycle(); idle_ex(); #1;
        total++; if (id_pred_taken !== 1'b1) begin bad++; $display("FAIL same_idx_new got=%b exp=1", id_pred_taken); end
        // 0x140 maps to index 0 and must not disturb index 5.
        drive_ex(1'b1, 1'b0, 1'b1, 32'h140, 1'b0, 1'b0, 32'h0);
        cycle(); cycle(); idle_ex(); #1;
        total++; if (id_pred_taken !== 1'b1) begin bad++; $display("FAIL alias_hold got=%b exp=1", id_pred_taken); end
    endtask

    task automatic test_random();
        logic ep; logic em; logic [31:0] er;
        for (int n = 0; n < 400; n++) begin
            id_is_branch = ($urandom_range(3) != 0);
            id_pc        = $urandom();
            drive_ex($urandom_range(7) != 0, $urandom_range(3) == 0, $urandom_range(3) != 0,
                     {$urandom_range(3), 26'h0, $urandom_range(15), 2'b00},
                     $urandom_range(1), $urandom_range(1), $urandom());
            // Sometimes make ID and EX share an entry.
            if ($urandom_range(3) == 0) id_pc = ex_pc ^ 32'h0001_0000;
            #3;
            ep = exp_pred(); em = exp_mis(); er = exp_redirect();
            total++; if (id_pred_taken !== ep || flush !== em || redirect_pc !== er) begin
                bad++; $display("FAIL rnd%0d pred/flush/redir got=%b/%b/%h exp=%b/%b/%h",
                                n, id_pred_taken, flush, redirect_pc, ep, em, er); end
            cycle();
            total++; if (branch_cnt !== m_br || mispred_cnt !== m_mis) begin
                bad++; $display("FAIL rnd%0d_cnt got=%0d/%0d exp=%0d/%0d", n, branch_cnt, mispred_cnt, m_br, m_mis); end
        end
        idle_ex();
    endtask

    task automatic test_reset_mid();
        int wrong;
        for (int k = 0; k < 10; k++) begin
            drive_ex(1'b1, 1'b0, 1'b1, 32'h8 + 32'(k) * 4, 1'b0, 1'b1, 32'h0);
            cycle();
        end
        rst = 1'b1;
        drive_ex(1'b1, 1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 32'h0);
        cycle();
        rst = 1'b0; idle_ex(); #1;
        total++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            bad++; $display("FAIL midrst_cnt got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt); end
        wrong = 0; id_is_branch = 1'b1;
        for (int i = 0; i < 16; i++) begin
            id_pc = 32'(i) * 4; #1;
            if (id_pred_taken !== 1'b0) wrong++;
        end
        total++; if (wrong != 0) begin bad++; $display("FAIL midrst_tbl got=%0d taken entries exp=0", wrong); end
        drive_ex(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234);
        #1;
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL wrap_redirect got=%b/%h exp=1/00000000", flush, redirect_pc); end
        cycle(); idle_ex(); id_pc = 32'hFFFF_FFFC; #1;
        total++; if (mispred_cnt !== 32'd1 || id_pred_taken !== 1'b0) begin
            bad++; $display("FAIL wrap_train got=%0d/%b exp=1/0", mispred_cnt, id_pred_taken); end
    endtask

    initial begin
        foreach (m_tbl[k]) m_tbl[k] = 1;
        m_br = 0; m_mis = 0;
        rst = 1'b1; id_is_branch = 1'b0; id_pc = 32'h0;
        idle_ex();
        #1;
        test_reset();
        test_mispredict();
        test_saturate();
        test_stall();
        test_same_index();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
